cpu_ctrl: RTL and testbench

//  Fetch/decode/sequencing unit of the one-cycle CPU. It sits directly upstream of cpu_data.
//  - Holds the program counter (PC) and addresses an asynchronous program ROM.
//  - Decodes each instruction word combinationally into cpu_data controls (ALU op,

---
 rtl/cpu_ctrl_if.sv | 49 ++++
 rtl/cpu_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_if
//  Description : Bus bundle between the fetch/decode unit (cpu_ctrl), the
//                program ROM and the cpu_data datapath.
//                master : cpu_ctrl side   (drives PC and decoded controls)
//                slave  : environment side (drives run, instruction, flags)
//  Signals     : run, instr, zero, carry            -> into cpu_ctrl
//                prog_addr, alu_op, en_acc, reg_f_sel, en_reg_f, in_b_sel,
//                imm, d_mem_addr, d_mem_addr_mode, en_d_mem, halted,
//                stack_err                          <- out of cpu_ctrl
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_ctrl_if #(
  parameter int WIDTH          = 8,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2,
  parameter int ALU_OP_SIZE    = 4
) ();
  logic                            run;
  logic [5+IN_B_SEL_SIZE+WIDTH-1:0] instr;
  logic                            zero;
  logic                            carry;
  logic [WIDTH-1:0]                prog_addr;
  logic [ALU_OP_SIZE-1:0]          alu_op;
  logic                            en_acc;
  logic [REG_F_SEL_SIZE-1:0]       reg_f_sel;
  logic                            en_reg_f;
  logic [IN_B_SEL_SIZE-1:0]        in_b_sel;
  logic [WIDTH-1:0]                imm;
  logic [WIDTH-1:0]                d_mem_addr;
  logic                            d_mem_addr_mode;
  logic                            en_d_mem;
  logic                            halted;
  logic                            stack_err;

  modport master (
    input  run, instr, zero, carry,
    output prog_addr, alu_op, en_acc, reg_f_sel, en_reg_f, in_b_sel,
           imm, d_mem_addr, d_mem_addr_mode, en_d_mem, halted, stack_err
  );

  modport slave (
    output run, instr, zero, carry,
    input  prog_addr, alu_op, en_acc, reg_f_sel, en_reg_f, in_b_sel,
           imm, d_mem_addr, d_mem_addr_mode, en_d_mem, halted, stack_err
  );
endinterface
`default_nettype wire

// File: rtl/cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl
//  Description : Fetch / decode / sequencing unit of the one-cycle CPU.
//                Holds the PC, decodes {OP,SRC,OPND} combinationally into
//                cpu_data controls and sequences JMP/JZ/JNZ/JC/CALL/RET/HALT.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - cpu_ctrl_if.master (run/instr/flags in, PC and
//                       decoded controls out)
//  Options     : CPU_CTRL_STACK_EN - when defined, adds a STACK_DEPTH-entry
//                return stack for CALL/RET; otherwise CALL/RET act as NOP
//                and stack_err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_ctrl #(
  parameter int WIDTH          = 8,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2,
  parameter int ALU_OP_SIZE    = 4,
  parameter int STACK_DEPTH    = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  cpu_ctrl_if.master  bus
);

  localparam int INSTR_W = 5 + IN_B_SEL_SIZE + WIDTH;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  localparam logic [4:0] OP_ST   = 5'h11;
  localparam logic [4:0] OP_STM  = 5'h12;
  localparam logic [4:0] OP_STI  = 5'h13;
  localparam logic [4:0] OP_JMP  = 5'h14;
  localparam logic [4:0] OP_JZ   = 5'h15;
  localparam logic [4:0] OP_JNZ  = 5'h16;
  localparam logic [4:0] OP_JC   = 5'h17;
  localparam logic [4:0] OP_CALL = 5'h18;
  localparam logic [4:0] OP_RET  = 5'h19;
  localparam logic [4:0] OP_HALT = 5'h1A;

  // Reject parameter sets the operand fields cannot support.
  if (STACK_DEPTH < 1 || REG_F_SEL_SIZE > WIDTH) begin : g_param_check
    $error("cpu_ctrl: illegal parameter combination");
  end

  // Instruction fields
  logic [4:0]               op;
  logic [IN_B_SEL_SIZE-1:0] src;
  logic [WIDTH-1:0]         opnd;
  assign op   = bus.instr[INSTR_W-1 -: 5];
  assign src  = bus.instr[WIDTH +: IN_B_SEL_SIZE];
  assign opnd = bus.instr[WIDTH-1:0];

  logic [0:0]       state, state_next;
  logic [WIDTH-1:0] pc, pc_next, pc_inc;
  logic             stack_err;

  assign pc_inc = pc + 1'b1;   // natural wrap 0xFF -> 0x00

`ifdef CPU_CTRL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]  sp, sp_dec;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic             push, pop, err_set;
  logic             sp_hi_unused;

  // SP counts filled entries: push writes slot SP, pop reads slot SP-1.
  assign sp_dec       = sp - 1'b1;
  assign push_idx     = sp[IDX_W-1:0];
  assign pop_idx      = sp_dec[IDX_W-1:0];
  assign sp_hi_unused = ^{sp, sp_dec};
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / PC logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    pc_next    = pc;
`ifdef CPU_CTRL_STACK_EN
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
`endif
    if (state == ST_RUN && bus.run) begin
      pc_next = pc_inc;
      case (op)
        OP_JMP:  pc_next = opnd;
        OP_JZ:   if (bus.zero)  pc_next = opnd;
        OP_JNZ:  if (!bus.zero) pc_next = opnd;
        OP_JC:   if (bus.carry) pc_next = opnd;
        OP_HALT: begin
          pc_next    = pc;
          state_next = ST_HALT;
        end
`ifdef CPU_CTRL_STACK_EN
        OP_CALL: begin
          if (sp == SP_FULL) begin
            err_set    = 1'b1;
            pc_next    = pc;
            state_next = ST_HALT;
          end else begin
            push    = 1'b1;
            pc_next = opnd;
          end
        end
        OP_RET: begin
          if (sp == '0) begin
            err_set    = 1'b1;
            pc_next    = pc;
            state_next = ST_HALT;
          end else begin
            pop     = 1'b1;
            pc_next = stack_mem[pop_idx];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.alu_op          = '0;
    bus.en_acc          = 1'b0;
    bus.en_reg_f        = 1'b0;
    bus.in_b_sel        = '0;
    bus.d_mem_addr_mode = 1'b0;
    bus.en_d_mem        = 1'b0;
    if (state == ST_RUN) begin
      if (!op[4]) begin
        bus.alu_op          = ALU_OP_SIZE'(op[3:0]);
        bus.en_acc          = bus.run;
        bus.in_b_sel        = src;
        // SRC all-ones selects data memory addressed indirectly via R[OPND]
        bus.d_mem_addr_mode = (src == {IN_B_SEL_SIZE{1'b1}});
      end else begin
        case (op)
          OP_ST:  bus.en_reg_f = bus.run;
          OP_STM: bus.en_d_mem = bus.run;
          OP_STI: begin
            bus.en_d_mem        = bus.run;
            bus.d_mem_addr_mode = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.prog_addr  = pc;
  assign bus.imm        = opnd;
  assign bus.d_mem_addr = opnd;
  assign bus.reg_f_sel  = opnd[REG_F_SEL_SIZE-1:0];
  assign bus.halted     = (state == ST_HALT);
  assign bus.stack_err  = stack_err;

`ifdef CPU_CTRL_STACK_EN
  // --------------------------------------------------------------------------
  // Return stack
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      if (push)    sp        <= sp + 1'b1;
      if (pop)     sp        <= sp_dec;
      if (err_set) stack_err <= 1'b1;
    end
  end

  // Contents need no reset; only entries below SP are ever read.
  always_ff @(posedge clk) begin
    if (push) stack_mem[push_idx] <= pc_inc;
  end
`else
  assign stack_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_ctrl
//  Description : Directed self-checking bench for cpu_ctrl. An asynchronous
//                ROM model is driven from prog_addr; the stimulus rewrites
//                ROM words to steer the PC through each scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] rom [256];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  cpu_ctrl_if #(.WIDTH(8), .REG_F_SEL_SIZE(4), .IN_B_SEL_SIZE(2), .ALU_OP_SIZE(4)) bus ();

  assign bus.instr = rom[bus.prog_addr];

  cpu_ctrl #(
    .WIDTH(8), .REG_F_SEL_SIZE(4), .IN_B_SEL_SIZE(2), .ALU_OP_SIZE(4), .STACK_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  function automatic logic [14:0] mk(input logic [4:0] op, input logic [1:0] src,
                                     input logic [7:0] opnd);
    return {op, src, opnd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {en_acc, en_reg_f, en_d_mem}
  task automatic chk_en(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, bus.en_acc, bus.en_reg_f, bus.en_d_mem}, {29'd0, exp});
  endtask

  task automatic chk_pc(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, bus.prog_addr}, {24'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mk(5'h10, 2'b00, 8'h00);
    rst = 1'b1; bus.run = 1'b0; bus.zero = 1'b0; bus.carry = 1'b0;

    // Reset state
    tick(); tick();
    chk_pc("reset_pc", 8'h00);
    chk("reset_halted", {31'd0, bus.halted}, 32'd0);
    chk("reset_stack_err", {31'd0, bus.stack_err}, 32'd0);
    chk_en("reset_en", 3'b000);

    // T1: NOP counting, JMP near top, wrap
    rom[3] = mk(5'h14, 2'b00, 8'hFE);
    rst = 1'b0; bus.run = 1'b1;
    tick(); chk_pc("t1_pc1", 8'h01); chk_en("t1_en_nop", 3'b000);
    tick(); chk_pc("t1_pc2", 8'h02);
    tick(); chk_pc("t1_pc3", 8'h03);
    tick(); chk_pc("t1_jmp_fe", 8'hFE);
    tick(); chk_pc("t1_pc_ff", 8'hFF);
    tick(); chk_pc("t1_wrap", 8'h00);

    // T2: ALU op 3, SRC=11, OPND=05 at PC 0
    rom[0] = mk(5'h03, 2'b11, 8'h05);
    #1;
    chk("t2_alu_op", {28'd0, bus.alu_op}, 32'h3);
    chk_en("t2_en", 3'b100);
    chk("t2_in_b_sel", {30'd0, bus.in_b_sel}, 32'h3);
    chk("t2_mode", {31'd0, bus.d_mem_addr_mode}, 32'd1);
    chk("t2_reg_f_sel", {28'd0, bus.reg_f_sel}, 32'h5);
    chk("t2_imm", {24'd0, bus.imm}, 32'h05);
    bus.run = 1'b0; #1;
    chk_en("t2_run0_en", 3'b000);
    bus.run = 1'b1;

    // ST / STI decode, then route to the branch test at 0x10
    rom[1]    = mk(5'h11, 2'b00, 8'h03);
    rom[2]    = mk(5'h13, 2'b00, 8'h00);
    rom[3]    = mk(5'h14, 2'b00, 8'h10);
    rom[8'h10] = mk(5'h15, 2'b00, 8'h40);
    rom[8'h11] = mk(5'h14, 2'b00, 8'h10);
    rom[8'h40] = mk(5'h14, 2'b00, 8'h10);
    tick(); chk_pc("st_pc", 8'h01);
    chk_en("st_en", 3'b010);
    chk("st_alu_op", {28'd0, bus.alu_op}, 32'h0);
    chk("st_reg_f_sel", {28'd0, bus.reg_f_sel}, 32'h3);
    tick(); chk_en("sti_en", 3'b001);
    chk("sti_mode", {31'd0, bus.d_mem_addr_mode}, 32'd1);
    tick(); tick(); chk_pc("t3_at_10", 8'h10);

    // T3: JZ 0x40
    tick(); chk_pc("t3_jz_not_taken", 8'h11);
    tick(); chk_pc("t3_back_10", 8'h10);
    bus.zero = 1'b1;
    tick(); chk_pc("t3_jz_taken", 8'h40);
    tick(); chk_pc("t3_back_10b", 8'h10);
    bus.run = 1'b0;
    tick(); chk_pc("t3_run0_hold", 8'h10);
    tick(); chk_pc("t3_run0_hold2", 8'h10);
    bus.run = 1'b1;

    // JNZ not taken (ZERO=1), then JC taken (CARRY=1) into the CALL site
    rom[8'h40] = mk(5'h16, 2'b00, 8'h50);
    rom[8'h41] = mk(5'h17, 2'b00, 8'h05);
    rom[5]     = mk(5'h18, 2'b00, 8'h20);
    rom[8'h20] = mk(5'h19, 2'b00, 8'h00);
    rom[6]     = mk(5'h10, 2'b00, 8'h00);
    rom[7]     = mk(5'h1A, 2'b00, 8'h00);
    bus.carry  = 1'b1;
    tick(); chk_pc("jz_to_40", 8'h40);
    tick(); chk_pc("jnz_not_taken", 8'h41);
    tick(); chk_pc("jc_taken", 8'h05);

`ifdef CPU_CTRL_STACK_EN
    // T4 (part 1): CALL 0x20 from 0x05, RET to 0x06
    tick(); chk_pc("t4_call", 8'h20);
    tick(); chk_pc("t4_ret", 8'h06);
`else
    // T6: CALL without a stack behaves as NOP
    tick(); chk_pc("t6_call_nop", 8'h06);
    chk("t6_stack_err", {31'd0, bus.stack_err}, 32'd0);
`endif

    // T5: HALT at 0x07
    tick(); chk_pc("t5_at_7", 8'h07);
    chk("t5_not_halted_yet", {31'd0, bus.halted}, 32'd0);
    tick();
    rom[7] = mk(5'h01, 2'b00, 8'h00);   // ALU word must not enable anything in HALT
    for (int i = 0; i < 10; i++) begin
      chk_pc("t5_halt_pc", 8'h07);
      chk("t5_halted", {31'd0, bus.halted}, 32'd1);
      chk_en("t5_halt_en", 3'b000);
      tick();
    end
    rst = 1'b1;
    tick();
    chk_pc("t5_rst_pc", 8'h00);
    chk("t5_rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("t5_rst_stack_err", {31'd0, bus.stack_err}, 32'd0);

`ifdef CPU_CTRL_STACK_EN
    // T4 (part 2): five nested CALLs overflow a 4-deep stack
    rom[0]     = mk(5'h18, 2'b00, 8'h30);
    rom[8'h30] = mk(5'h18, 2'b00, 8'h31);
    rom[8'h31] = mk(5'h18, 2'b00, 8'h32);
    rom[8'h32] = mk(5'h18, 2'b00, 8'h33);
    rom[8'h33] = mk(5'h18, 2'b00, 8'h34);
    rst = 1'b0;
    tick(); chk_pc("t4_call1", 8'h30);
    tick(); tick(); tick(); chk_pc("t4_call4", 8'h33);
    chk("t4_no_err_yet", {31'd0, bus.stack_err}, 32'd0);
    tick();
    chk("t4_ovf_err", {31'd0, bus.stack_err}, 32'd1);
    chk("t4_ovf_halted", {31'd0, bus.halted}, 32'd1);
    chk_pc("t4_ovf_pc", 8'h33);
    tick(); chk_pc("t4_ovf_frozen", 8'h33);
    chk("t4_err_sticky", {31'd0, bus.stack_err}, 32'd1);

    // RET on an empty stack
    rst = 1'b1; rom[0] = mk(5'h19, 2'b00, 8'h00);
    tick();
    chk("t4_rst_err", {31'd0, bus.stack_err}, 32'd0);
    rst = 1'b0;
    tick();
    chk("t4_udf_err", {31'd0, bus.stack_err}, 32'd1);
    chk("t4_udf_halted", {31'd0, bus.halted}, 32'd1);
    chk_pc("t4_udf_pc", 8'h00);
`else
    // CALL/RET from a fresh reset: plain increments, no error
    rom[0] = mk(5'h18, 2'b00, 8'h30);
    rom[1] = mk(5'h19, 2'b00, 8'h00);
    rst = 1'b0;
    tick(); chk_pc("t6_call_pc1", 8'h01);
    tick(); chk_pc("t6_ret_pc2", 8'h02);
    chk("t6_ret_no_err", {31'd0, bus.stack_err}, 32'd0);
    chk("t6_ret_no_halt", {31'd0, bus.halted}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
